// File: rtl/am_similarity_accumulator.sv
// ---------------------------------------------------------------------------
// am_similarity_accumulator
//
// Sparse-HDC similarity engine. One query hypervector is streamed in
// CHUNK_W-bit slices together with the matching slice of every class
// hypervector held in associative memory. For each class the block
// accumulates popcount(query & class) over all NUM_CHUNKS slices. When the
// last slice has been summed it raises sims_valid for one cycle, which feeds
// the inferring_class input of the AM tree comparator.
//
// Optional feature (macro AM_POPCNT_PIPE_EN):
//   defined   - the AND+popcount result is registered before the add. A
//               one-cycle DRAIN state commits the last addend, so sims_valid
//               comes one cycle later. Throughput stays at one chunk/cycle.
//   undefined - popcount and add happen in the acceptance cycle; no DRAIN.
//
// Ports:
//   clk                clock
//   nrst               asynchronous active-low reset
//   start              pulse, begins a new query (honoured only when idle)
//   chunk_valid        query_chunk / am_chunk carry a valid slice
//   chunk_ready        block accepts a slice (high only while accumulating)
//   query_chunk        query hypervector slice
//   am_chunk           class hypervector slices, one per class
//   busy               query in progress
//   sims_valid         one-cycle strobe, similarity_values are final
//   similarity_values  per-class similarity, held until the next start
// ---------------------------------------------------------------------------
module am_similarity_accumulator #(
  parameter int NUM_CLASSES = 26,
  parameter int CHUNK_W     = 40,
  parameter int NUM_CHUNKS  = 125,
  parameter int SIM_W       = 13
) (
  input  logic                                  clk,
  input  logic                                  nrst,
  input  logic                                  start,
  input  logic                                  chunk_valid,
  output logic                                  chunk_ready,
  input  logic [CHUNK_W-1:0]                    query_chunk,
  input  logic [NUM_CLASSES-1:0][CHUNK_W-1:0]   am_chunk,
  output logic                                  busy,
  output logic                                  sims_valid,
  output logic [NUM_CLASSES-1:0][SIM_W-1:0]     similarity_values
);

  localparam int POP_W = $clog2(CHUNK_W + 1);
  localparam int CNT_W = $clog2(NUM_CHUNKS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                             state;
  logic [CNT_W-1:0]                   chunk_cnt;
  logic [NUM_CLASSES-1:0][POP_W-1:0]  pop;
  logic                               accept;
  logic                               last_chunk;

`ifdef AM_POPCNT_PIPE_EN
  logic [NUM_CLASSES-1:0][POP_W-1:0]  pop_q;
  logic                               pipe_vld;
`endif

  // chunk_ready is a registered output that is high exactly in ACCUM, so the
  // handshake needs no separate state decode.
  assign accept     = chunk_valid & chunk_ready;
  assign last_chunk = (chunk_cnt == CNT_W'(NUM_CHUNKS - 1));

  // Per-class popcount of the overlap between query and class slice.
  always_comb begin
    for (int c = 0; c < NUM_CLASSES; c++) begin
      // NOTE: every combinational output gets a default before the loop so no
      // path leaves it unassigned, which would infer a latch.
      pop[c] = '0;
      for (int b = 0; b < CHUNK_W; b++) begin
        pop[c] = pop[c] + POP_W'(query_chunk[b] & am_chunk[c][b]);
      end
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state             <= IDLE;
      chunk_cnt         <= '0;
      // NOTE: the accumulator bank is reset explicitly; it is visible on the
      // outputs and must read zero after reset, unlike a plain data buffer.
      similarity_values <= '0;
      chunk_ready       <= 1'b0;
      busy              <= 1'b0;
      sims_valid        <= 1'b0;
`ifdef AM_POPCNT_PIPE_EN
      pop_q             <= '0;
      pipe_vld          <= 1'b0;
`endif
    end else begin
      sims_valid <= 1'b0;

`ifdef AM_POPCNT_PIPE_EN
      // Stage 1 registers the popcounts of an accepted chunk, stage 2 adds
      // them one cycle later. pipe_vld is never set in IDLE, so the clear on
      // start below cannot collide with a pending add.
      pipe_vld <= accept;
      if (accept) pop_q <= pop;
      if (pipe_vld) begin
        for (int c = 0; c < NUM_CLASSES; c++) begin
          similarity_values[c] <= similarity_values[c] + SIM_W'(pop_q[c]);
        end
      end
`endif

      case (state)
        IDLE: begin
          if (start) begin
            similarity_values <= '0;
            chunk_cnt         <= '0;
            chunk_ready       <= 1'b1;
            busy              <= 1'b1;
            state             <= ACCUM;
          end
        end

        ACCUM: begin
          if (accept) begin
`ifndef AM_POPCNT_PIPE_EN
            for (int c = 0; c < NUM_CLASSES; c++) begin
              similarity_values[c] <= similarity_values[c] + SIM_W'(pop[c]);
            end
`endif
            if (last_chunk) begin
              chunk_cnt   <= '0;
              chunk_ready <= 1'b0;
`ifdef AM_POPCNT_PIPE_EN
              state       <= DRAIN;
`else
              state       <= DONE;
              sims_valid  <= 1'b1;
`endif
            end else begin
              chunk_cnt <= chunk_cnt + CNT_W'(1);
            end
          end
        end

`ifdef AM_POPCNT_PIPE_EN
        DRAIN: begin
          // The last addend is committed by the pipeline add above this edge.
          state      <= DONE;
          sims_valid <= 1'b1;
        end
`endif

        DONE: begin
          // A start arriving together with sims_valid is dropped here.
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_am_similarity_accumulator.sv
// ---------------------------------------------------------------------------
// tb_am_similarity_accumulator
//
// Self-checking bench for am_similarity_accumulator. A behavioural model
// tracks which query is running, how many slices were accepted, the running
// popcount sums and the cycle on which sims_valid is due. A compare process
// checks every DUT output against it on each falling edge. Literal
// expectations for structured queries and a whole-HV golden sum for a stored
// query pin the model itself.
// ---------------------------------------------------------------------------
module tb_am_similarity_accumulator;

  localparam int NC = 26;
  localparam int CW = 40;
  localparam int NK = 125;
  localparam int SW = 13;
`ifdef AM_POPCNT_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                     clk = 1'b0;
  logic                     nrst = 1'b0;
  logic                     start = 1'b0;
  logic                     chunk_valid = 1'b0;
  logic                     chunk_ready;
  logic [CW-1:0]            query_chunk = '0;
  logic [NC-1:0][CW-1:0]    am_chunk = '0;
  logic                     busy;
  logic                     sims_valid;
  logic [NC-1:0][SW-1:0]    similarity_values;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  am_similarity_accumulator #(
    .NUM_CLASSES (NC),
    .CHUNK_W     (CW),
    .NUM_CHUNKS  (NK),
    .SIM_W       (SW)
  ) dut (
    .clk               (clk),
    .nrst              (nrst),
    .start             (start),
    .chunk_valid       (chunk_valid),
    .chunk_ready       (chunk_ready),
    .query_chunk       (query_chunk),
    .am_chunk          (am_chunk),
    .busy              (busy),
    .sims_valid        (sims_valid),
    .similarity_values (similarity_values)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int cyc    = 0;
  bit m_busy = 1'b0;
  bit m_acc  = 1'b0;
  int m_n    = 0;
  int m_sum[NC];
  int exp_sv = -100;
  int vmode  = 1;   // 0: partial, not checked; 1: must be zero; 2: final sums

  initial foreach (m_sum[c]) m_sum[c] = 0;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_busy = 1'b0;
      m_acc  = 1'b0;
      m_n    = 0;
      exp_sv = -100;
      vmode  = 1;
      foreach (m_sum[c]) m_sum[c] = 0;
    end else begin
      cyc++;
      if (m_acc && chunk_valid) begin
        foreach (m_sum[c]) m_sum[c] += $countones(query_chunk & am_chunk[c]);
        m_n++;
        vmode = 0;
        if (m_n == NK) begin
          m_acc  = 1'b0;
          exp_sv = cyc + LAT - 1;
        end
      end else if (!m_busy && start) begin
        m_busy = 1'b1;
        m_acc  = 1'b1;
        m_n    = 0;
        vmode  = 1;
        foreach (m_sum[c]) m_sum[c] = 0;
      end
      if (cyc == exp_sv) vmode = 2;
      if (cyc == exp_sv + 1) m_busy = 1'b0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    check("chunk_ready", 64'(chunk_ready), 64'(m_acc));
    check("busy", 64'(busy), 64'(m_busy));
    check("sims_valid", 64'(sims_valid), 64'(nrst && (cyc == exp_sv)));
    if (vmode == 1) begin
      for (int c = 0; c < NC; c++)
        check($sformatf("sim_zero[%0d]", c), 64'(similarity_values[c]), 64'd0);
    end else if (vmode == 2) begin
      for (int c = 0; c < NC; c++)
        check($sformatf("sim[%0d]", c), 64'(similarity_values[c]), 64'(m_sum[c]));
    end
  end

  // ---------------- stimulus ----------------
  logic [CW-1:0] q_mem [NK];
  logic [CW-1:0] a_mem [NK][NC];

  function automatic logic [CW-1:0] rnd_w();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[CW-1:0];
  endfunction

  task automatic drive_junk();
    query_chunk = rnd_w();
    for (int c = 0; c < NC; c++) am_chunk[c] = rnd_w();
  endtask

  task automatic drive_chunk(input int mode, input int k);
    logic [CW-1:0] ones;
    ones = '1;
    case (mode)
      1: begin
        query_chunk = ones;
        for (int c = 0; c < NC; c++) am_chunk[c] = (c == 3) ? ones : '0;
      end
      2: begin
        query_chunk = CW'(8'hFF);
        for (int c = 0; c < NC; c++) am_chunk[c] = (CW'(1) << (c % 9)) - CW'(1);
      end
      3: begin
        query_chunk = q_mem[k];
        for (int c = 0; c < NC; c++) am_chunk[c] = a_mem[k][c];
      end
      default: drive_junk();
    endcase
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start       = 1'b0;
      chunk_valid = $urandom_range(1);
      drive_junk();
    end
    @(negedge clk);
    chunk_valid = 1'b0;
  endtask

  // Runs one query. extra_start_at pulses start while that slice is offered,
  // abort_at pulls nrst once that many slices are in, start_in_done raises
  // start in the sims_valid cycle.
  task automatic run_query(input int mode, input int bubble_pct, input int extra_start_at,
                           input int abort_at, input bit start_in_done);
    int k = 0;
    int guard = 0;
    @(negedge clk);
    start       = 1'b1;
    chunk_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (k < NK && guard < 4000) begin
      guard++;
      if (k == abort_at) begin
        chunk_valid = 1'b0;
        #2 nrst = 1'b0;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        return;
      end
      start = (k == extra_start_at);
      if ($urandom_range(99) < bubble_pct) begin
        chunk_valid = 1'b0;
        drive_junk();
      end else begin
        chunk_valid = 1'b1;
        drive_chunk(mode, k);
        if (chunk_ready) k++;
      end
      @(negedge clk);
    end
    chunk_valid = 1'b0;
    start       = 1'b0;
    check("chunk_budget", 64'(k), 64'(NK));
    guard = 0;
    while (!sims_valid && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    check("sims_valid_seen", 64'(sims_valid), 64'd1);
    if (start_in_done) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic check_mem_golden(input string tag);
    int g;
    for (int c = 0; c < NC; c++) begin
      g = 0;
      for (int k = 0; k < NK; k++) g += $countones(q_mem[k] & a_mem[k][c]);
      check($sformatf("%s[%0d]", tag, c), 64'(similarity_values[c]), 64'(g));
    end
  endtask

  initial begin
    for (int k = 0; k < NK; k++) begin
      q_mem[k] = rnd_w();
      for (int c = 0; c < NC; c++) a_mem[k][c] = rnd_w();
    end

    nrst = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    idle(3);

    // All-ones query against a single all-ones class.
    run_query(1, 0, -1, -1, 1'b0);
    check("t1_sim3", 64'(similarity_values[3]), 64'd5000);
    check("t1_sim0", 64'(similarity_values[0]), 64'd0);
    check("t1_sim25", 64'(similarity_values[25]), 64'd0);
    idle(4);

    // Low-byte query, class c has c%9 low bits set; start in DONE is dropped.
    run_query(2, 0, -1, -1, 1'b1);
    check("t2_sim8", 64'(similarity_values[8]), 64'd1000);
    check("t2_sim9", 64'(similarity_values[9]), 64'd0);
    check("t2_sim5", 64'(similarity_values[5]), 64'd625);
    check("t2_busy_after_done_start", 64'(busy), 64'd0);
    idle(3);

    // Consecutive query straight after: old results must clear on start.
    run_query(1, 10, -1, -1, 1'b0);
    check("t6_sim3", 64'(similarity_values[3]), 64'd5000);
    check("t6_sim8", 64'(similarity_values[8]), 64'd0);

    // Random HVs with 50% bubbles.
    for (int i = 0; i < 3; i++) begin
      idle($urandom_range(1, 5));
      run_query(0, 50, -1, -1, 1'b0);
    end

    // Stored query, once with a start pulse mid-query, once without.
    idle(2);
    run_query(3, 30, 60, -1, 1'b0);
    check_mem_golden("t4_restart");
    idle(2);
    run_query(3, 0, -1, -1, 1'b0);
    check_mem_golden("t4_plain");

    // Reset after 70 slices, then a fresh query.
    idle(2);
    run_query(0, 20, -1, 70, 1'b0);
    idle(2);
    run_query(1, 25, -1, -1, 1'b0);
    check("t5_sim3", 64'(similarity_values[3]), 64'd5000);
    check("t5_sim1", 64'(similarity_values[1]), 64'd0);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
